// File: rtl/sid_pipe_sched_if.sv
// sid_pipe_sched_if: frame start, busy and pipeline strobes between the scheduler and the audio top level
interface sid_pipe_sched_if;
  logic       start;
  logic       busy;
  logic       voice_load;
  logic [1:0] load_sid;
  logic [1:0] load_voice;
  logic       voice_active;
  logic       voice_cap;
  logic [1:0] cap_sid;
  logic [1:0] cap_voice;
  logic       flt_setup;
  logic [1:0] flt_sid;
  logic [2:0] flt_stage;
  logic       flt_done;
  logic       frame_done;
  logic       overrun;
  modport master (
    input  start,
    output busy, voice_load, load_sid, load_voice, voice_active, voice_cap, cap_sid, cap_voice,
           flt_setup, flt_sid, flt_stage, flt_done, frame_done, overrun
  );
  modport slave (
    output start,
    input  busy, voice_load, load_sid, load_voice, voice_active, voice_cap, cap_sid, cap_voice,
           flt_setup, flt_sid, flt_stage, flt_done, frame_done, overrun
  );
endinterface

// File: rtl/sid_pipe_sched.sv
// sid_pipe_sched: sequences all SID voices through one voice pipeline, then each SID through one filter pipeline
module sid_pipe_sched #(
  parameter int N_SID      = 2,
  parameter int N_VOICE    = 3,
  parameter int VOICE_LAT  = 1,
  parameter int FLT_STAGES = 8
) (
  input logic             clk,
  input logic             rst_n,
  sid_pipe_sched_if.master bus
);
  localparam int D = VOICE_LAT + 1;
  typedef enum logic [1:0] {IDLE, WAIT, SETUP, RUN} state_t;
  state_t              r_state;
  logic                r_busy, r_load, r_act, r_setup, r_fdone, r_frdone, r_ovr;
  logic [1:0]          r_lsid, r_lvoice, r_s, r_fsid;
  logic [2:0]          r_stage, r_ncap;
  logic [D-1:0]        r_d;
  logic [D-1:0][1:0]   r_dsid, r_dvoice;
  logic                w_acc, w_last_load, w_pre, w_pen, w_end, w_lastsid, w_rdy_s, w_rdy_n;
  logic [1:0]          w_s1;
  assign w_acc       = bus.start && (!r_busy || r_frdone);
  assign w_last_load = r_lsid == 2'(N_SID - 1) && r_lvoice == 2'(N_VOICE - 1);
  // a SID's last voice is captured on the cycle after it reaches tap D-2
  assign w_pre       = r_d[D-2] && r_dvoice[D-2] == 2'(N_VOICE - 1);
  assign w_s1        = r_s + 2'd1;
  assign w_lastsid   = r_s == 2'(N_SID - 1);
  assign w_pen       = r_stage == 3'(FLT_STAGES - 2);
  assign w_end       = r_stage == 3'(FLT_STAGES - 1);
  assign w_rdy_s     = (w_pre && r_dsid[D-2] == r_s) || {1'b0, r_s} < r_ncap;
  assign w_rdy_n     = (w_pre && r_dsid[D-2] == w_s1) || {1'b0, w_s1} < r_ncap;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_load   <= 1'b0;
      r_act    <= 1'b0;
      r_setup  <= 1'b0;
      r_fdone  <= 1'b0;
      r_frdone <= 1'b0;
      r_ovr    <= 1'b0;
      r_lsid   <= '0;
      r_lvoice <= '0;
      r_s      <= '0;
      r_fsid   <= '0;
      r_stage  <= '0;
      r_ncap   <= '0;
      r_d      <= '0;
      r_dsid   <= '0;
      r_dvoice <= '0;
    end else begin
      r_ovr    <= bus.start && !w_acc;
      r_busy   <= w_acc || (r_busy && !r_frdone);
      r_load   <= w_acc || (r_load && !w_last_load);
      if (r_load) begin
        r_lvoice <= r_lvoice == 2'(N_VOICE - 1) ? 2'd0 : r_lvoice + 2'd1;
        r_lsid   <= r_lvoice != 2'(N_VOICE - 1) ? r_lsid : w_last_load ? 2'd0 : r_lsid + 2'd1;
      end
      r_d      <= {r_d[D-2:0], r_load};
      r_dsid   <= {r_dsid[D-2:0], r_lsid};
      r_dvoice <= {r_dvoice[D-2:0], r_lvoice};
      r_act    <= r_load || |r_d[D-2:0];
      r_ncap   <= w_acc ? 3'd0 : r_ncap + 3'(w_pre);
      r_stage  <= (r_state == RUN && !w_end) ? r_stage + 3'd1 : 3'd0;
      r_fdone  <= r_state == RUN && w_pen;
      r_frdone <= r_state == RUN && w_pen && w_lastsid;
      r_setup  <= 1'b0;
      case (r_state)
        IDLE: if (w_acc) begin
          r_state <= WAIT;
          r_s     <= '0;
        end
        WAIT: if (w_rdy_s) begin
          r_state <= SETUP;
          r_setup <= 1'b1;
          r_fsid  <= r_s;
        end
        SETUP: r_state <= RUN;
        RUN: begin
          // the next SID's setup may overlap the current run's final stage
          if (w_lastsid) begin
            if (w_end) begin
              r_state <= w_acc ? WAIT : IDLE;
              r_s     <= '0;
            end
          end else if ((w_pen || w_end) && w_rdy_n) begin
            r_state <= SETUP;
            r_setup <= 1'b1;
            r_s     <= w_s1;
            r_fsid  <= w_s1;
          end else if (w_end) begin
            r_state <= WAIT;
            r_s     <= w_s1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.busy         = r_busy;
  assign bus.voice_load   = r_load;
  assign bus.load_sid     = r_lsid;
  assign bus.load_voice   = r_lvoice;
  assign bus.voice_active = r_act;
  assign bus.voice_cap    = r_d[D-1];
  assign bus.cap_sid      = r_dsid[D-1];
  assign bus.cap_voice    = r_dvoice[D-1];
  assign bus.flt_setup    = r_setup;
  assign bus.flt_sid      = r_fsid;
  assign bus.flt_stage    = r_stage;
  assign bus.flt_done     = r_fdone;
  assign bus.frame_done   = r_frdone;
  assign bus.overrun      = r_ovr;
endmodule

// File: tb/tb_sid_pipe_sched.sv
// tb_sid_pipe_sched: directed frame timelines for the default and a single-SID, two-cycle-latency scheduler
module tb_sid_pipe_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  sid_pipe_sched_if a ();
  sid_pipe_sched_if b ();
  sid_pipe_sched u_dut (.clk(clk), .rst_n(rst_n), .bus(a));
  sid_pipe_sched #(.N_SID(1), .VOICE_LAT(2)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b));
  logic [20:0] w_oa, w_ob;
  assign w_oa = {a.busy, a.voice_load, a.load_sid, a.load_voice, a.voice_active, a.voice_cap, a.cap_sid,
                 a.cap_voice, a.flt_setup, a.flt_sid, a.flt_stage, a.flt_done, a.frame_done, a.overrun};
  assign w_ob = {b.busy, b.voice_load, b.load_sid, b.load_voice, b.voice_active, b.voice_cap, b.cap_sid,
                 b.cap_voice, b.flt_setup, b.flt_sid, b.flt_stage, b.flt_done, b.frame_done, b.overrun};
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // default-parameter frame, r cycles after the start was sampled
  task automatic chk_frame(input int g, input int r, input logic ovr);
    logic ld, cp;
    ld = r >= 1 && r <= 6;
    cp = r >= 3 && r <= 8;
    chk($sformatf("c%0d busy", g), a.busy, r >= 1 && r <= 21);
    chk($sformatf("c%0d voice_load", g), a.voice_load, ld);
    if (ld) begin
      chk($sformatf("c%0d load_sid", g), a.load_sid, (r - 1) / 3);
      chk($sformatf("c%0d load_voice", g), a.load_voice, (r - 1) % 3);
    end
    chk($sformatf("c%0d voice_active", g), a.voice_active, r >= 2 && r <= 8);
    chk($sformatf("c%0d voice_cap", g), a.voice_cap, cp);
    if (cp) begin
      chk($sformatf("c%0d cap_sid", g), a.cap_sid, (r - 3) / 3);
      chk($sformatf("c%0d cap_voice", g), a.cap_voice, (r - 3) % 3);
    end
    chk($sformatf("c%0d flt_setup", g), a.flt_setup, r == 5 || r == 13);
    if (r >= 5 && r <= 12) chk($sformatf("c%0d flt_sid", g), a.flt_sid, 0);
    if (r >= 14 && r <= 21) chk($sformatf("c%0d flt_sid", g), a.flt_sid, 1);
    chk($sformatf("c%0d flt_stage", g), a.flt_stage,
        (r >= 6 && r <= 13) ? r - 6 : (r >= 14 && r <= 21) ? r - 14 : 0);
    chk($sformatf("c%0d flt_done", g), a.flt_done, r == 13 || r == 21);
    chk($sformatf("c%0d frame_done", g), a.frame_done, r == 21);
    chk($sformatf("c%0d overrun", g), a.overrun, ovr);
  endtask
  initial begin
    a.start = 1'b0;
    b.start = 1'b0;
    repeat (2) step();
    chk("reset outs a", w_oa, 0);
    chk("reset outs b", w_ob, 0);
    rst_n = 1'b1;
    step();
    // frame A at 0, overrun start at 10, restart frame B on frame_done at 21
    for (int g = 0; g <= 30; g++) begin
      a.start = (g == 0 || g == 10 || g == 21);
      chk_frame(g, g >= 22 ? g - 21 : g, g == 11);
      if (g < 30) step();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("async rst outs a", w_oa, 0);
    chk("async rst outs b", w_ob, 0);
    a.start = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    for (int r = 0; r <= 23; r++) begin
      a.start = (r == 0);
      chk_frame(200 + r, r, 1'b0);
      step();
    end
    a.start = 1'b0;
    for (int r = 0; r <= 16; r++) begin
      b.start = (r == 0);
      chk($sformatf("n1 c%0d busy", r), b.busy, r >= 1 && r <= 14);
      chk($sformatf("n1 c%0d voice_load", r), b.voice_load, r >= 1 && r <= 3);
      chk($sformatf("n1 c%0d voice_cap", r), b.voice_cap, r >= 4 && r <= 6);
      if (r >= 4 && r <= 6) chk($sformatf("n1 c%0d cap_voice", r), b.cap_voice, r - 4);
      chk($sformatf("n1 c%0d flt_setup", r), b.flt_setup, r == 6);
      chk($sformatf("n1 c%0d flt_stage", r), b.flt_stage, (r >= 7 && r <= 14) ? r - 7 : 0);
      chk($sformatf("n1 c%0d flt_done", r), b.flt_done, r == 14);
      chk($sformatf("n1 c%0d frame_done", r), b.frame_done, r == 14);
      chk($sformatf("n1 c%0d overrun", r), b.overrun, 0);
      step();
    end
    b.start = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
